// File: rtl/ddr_fb_pkg.sv
// Shared definitions for the framebuffer DDR write path.
//   LANES/PIXEL_W : eight 16-bit pixel lanes per DDR word
//   WORD_W/STRB_W : 128-bit DDR data word with a 16-bit byte strobe
//   WRITE_BUS_W   : write-data FIFO bus width, {data, strb}
//   WORD_ADDR_W   : 128-bit-word address width
package ddr_fb_pkg;

  localparam int unsigned LANES       = 8;
  localparam int unsigned PIXEL_W     = 16;
  localparam int unsigned WORD_W      = 128;
  localparam int unsigned STRB_W      = 16;
  localparam int unsigned WRITE_BUS_W = 144;
  localparam int unsigned WORD_ADDR_W = 27;

  typedef struct packed {
    logic [WORD_W-1:0]      data;
    logic [STRB_W-1:0]      strb;
    logic [WORD_ADDR_W-1:0] addr;
    logic                   last;
  } ddr_write_word_t;

  // Two strobe bits (one pixel = two bytes) for the given lane.
  function automatic logic [STRB_W-1:0] lane_strb(input logic [2:0] lane);
    return STRB_W'(2'b11) << {lane, 1'b0};
  endfunction

  // Data-bit mask covering the given lane.
  function automatic logic [WORD_W-1:0] lane_mask(input logic [2:0] lane);
    return WORD_W'({PIXEL_W{1'b1}}) << {lane, 4'b0000};
  endfunction

endpackage

// File: rtl/ddr_dual_handshake_reg.sv
// Output word register feeding two independent FIFOs (data and address).
// Each side completes its own valid/ready handshake; the word retires in
// the cycle the second handshake happens (or both in the same cycle).
//   clk_in, rst_in : clock, asynchronous active-high reset
//   load           : capture load_word (only honoured while not pending)
//   load_word      : word to present
//   data_ready     : write-data FIFO ready
//   addr_ready     : write-address FIFO ready
//   pending        : a word is held
//   data_valid     : write-data valid
//   addr_valid     : write-address valid
//   word           : held word (stable while pending)
//   retire         : one-cycle pulse when both sides have taken the word
module ddr_dual_handshake_reg
  import ddr_fb_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            load,
  input  ddr_write_word_t load_word,
  input  logic            data_ready,
  input  logic            addr_ready,
  output logic            pending,
  output logic            data_valid,
  output logic            addr_valid,
  output ddr_write_word_t word,
  output logic            retire
);

  logic pending_q;
  logic data_done_q;
  logic addr_done_q;
  ddr_write_word_t word_q;
  logic data_hs;
  logic addr_hs;

  assign data_valid = pending_q && !data_done_q;
  assign addr_valid = pending_q && !addr_done_q;
  assign data_hs    = data_valid && data_ready;
  assign addr_hs    = addr_valid && addr_ready;
  assign retire     = pending_q && (data_done_q || data_hs) && (addr_done_q || addr_hs);

  assign pending = pending_q;
  assign word    = word_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending_q   <= 1'b0;
      data_done_q <= 1'b0;
      addr_done_q <= 1'b0;
      word_q      <= '0;
    end else if (retire) begin
      pending_q   <= 1'b0;
      data_done_q <= 1'b0;
      addr_done_q <= 1'b0;
    end else if (pending_q) begin
      if (data_hs) data_done_q <= 1'b1;
      if (addr_hs) addr_done_q <= 1'b1;
    end else if (load) begin
      pending_q <= 1'b1;
      word_q    <= load_word;
    end
  end

endmodule

// File: rtl/ddr_write_packer.sv
// Pixel-write coalescer. Merges 16-bit pixel writes that land in the same
// 128-bit DDR word into one strobed word and hands it to the DDR wrapper's
// write-data and write-address FIFOs.
//   clk_in, rst_in            : clock, asynchronous active-high reset
//   pixel_valid/ready/addr/data : pixel write request stream
//   flush_in / flush_done_out : end-of-frame flush request / completion pulse
//   data_fifo_*, write_data_out, last_write_out : write-data FIFO side
//   addr_fifo_*, write_addr_out                 : write-address FIFO side
//   words_emitted_out         : count of retired words (wraps)
module ddr_write_packer
  import ddr_fb_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned PIX_ADDR_W = 30
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   pixel_valid_in,
  output logic                   pixel_ready_out,
  input  logic [PIX_ADDR_W-1:0]  pixel_addr_in,
  input  logic [PIXEL_W-1:0]     pixel_data_in,
  input  logic                   flush_in,
  output logic                   flush_done_out,
  output logic                   data_fifo_valid_out,
  input  logic                   data_fifo_ready_in,
  output logic [WRITE_BUS_W-1:0] write_data_out,
  output logic                   last_write_out,
  output logic                   addr_fifo_valid_out,
  input  logic                   addr_fifo_ready_in,
  output logic [PIX_ADDR_W-4:0]  write_addr_out,
  output logic [31:0]            words_emitted_out
);

  localparam int unsigned WA_W  = PIX_ADDR_W - 3;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic              run_q;
  logic              acc_valid_q;
  logic [WA_W-1:0]   acc_addr_q;
  logic [WORD_W-1:0] acc_data_q;
  logic [STRB_W-1:0] acc_strb_q;
  logic [CNT_W-1:0]  tmo_cnt_q;
  logic              flush_pending_q;
  logic [31:0]       words_q;

  logic              accept;
  logic              hit;
  logic              miss_move;
  logic              flush_move;
  logic              flush_empty;
  logic              tmo_move;
  logic              out_load;
  logic [2:0]        lane;
  logic [WA_W-1:0]   pix_word;
  logic [WORD_W-1:0] lane_data;
  logic [WORD_W-1:0] merged_data;
  logic [STRB_W-1:0] merged_strb;

  logic            out_pending;
  logic            retire;
  ddr_write_word_t load_word;
  ddr_write_word_t out_word;

  assign lane     = pixel_addr_in[2:0];
  assign pix_word = pixel_addr_in[PIX_ADDR_W-1:3];

  // run_q keeps ready low during and immediately out of reset; ready is
  // built from registers only, never from the FIFO readies.
  assign pixel_ready_out = run_q && !out_pending && !flush_pending_q;
  assign accept          = pixel_valid_in && pixel_ready_out;
  assign hit             = acc_valid_q && (acc_addr_q == pix_word);
  assign miss_move       = accept && acc_valid_q && !hit;

  assign flush_move  = flush_pending_q && !out_pending && acc_valid_q;
  assign flush_empty = flush_pending_q && !out_pending && !acc_valid_q;
  // An accept in the same cycle wins: it clears the idle counter.
  assign tmo_move    = acc_valid_q && (tmo_cnt_q == TMO_LAST) && !out_pending &&
                       !flush_pending_q && !accept;
  assign out_load    = miss_move || flush_move || tmo_move;

  assign lane_data = WORD_W'(pixel_data_in) << {lane, 4'b0000};

  always_comb begin
    merged_data = (acc_data_q & ~lane_mask(lane)) | lane_data;
    merged_strb = acc_strb_q | lane_strb(lane);
  end

  always_comb begin
    load_word      = '0;
    load_word.data = acc_data_q;
    load_word.strb = acc_strb_q;
    load_word.addr = WORD_ADDR_W'(acc_addr_q);
    load_word.last = flush_move;
  end

  ddr_dual_handshake_reg u_out (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .load       (out_load),
    .load_word  (load_word),
    .data_ready (data_fifo_ready_in),
    .addr_ready (addr_fifo_ready_in),
    .pending    (out_pending),
    .data_valid (data_fifo_valid_out),
    .addr_valid (addr_fifo_valid_out),
    .word       (out_word),
    .retire     (retire)
  );

  assign write_data_out    = {out_word.data, out_word.strb};
  assign write_addr_out    = WA_W'(out_word.addr);
  assign last_write_out    = out_word.last;
  assign words_emitted_out = words_q;
  assign flush_done_out    = flush_empty || (retire && out_word.last);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      run_q           <= 1'b0;
      acc_valid_q     <= 1'b0;
      acc_addr_q      <= '0;
      acc_data_q      <= '0;
      acc_strb_q      <= '0;
      tmo_cnt_q       <= '0;
      flush_pending_q <= 1'b0;
      words_q         <= '0;
    end else begin
      run_q <= 1'b1;

      if (accept) begin
        acc_valid_q <= 1'b1;
        acc_addr_q  <= pix_word;
        if (hit) begin
          acc_data_q <= merged_data;
          acc_strb_q <= merged_strb;
        end else begin
          acc_data_q <= lane_data;
          acc_strb_q <= lane_strb(lane);
        end
      end else if (flush_move || tmo_move) begin
        acc_valid_q <= 1'b0;
      end

      if (accept || !acc_valid_q) begin
        tmo_cnt_q <= '0;
      end else if (tmo_cnt_q != TMO_LAST) begin
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end

      if (flush_done_out) begin
        flush_pending_q <= 1'b0;
      end else if (flush_in) begin
        flush_pending_q <= 1'b1;
      end

      if (retire) words_q <= words_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_ddr_write_packer.sv
module tb_ddr_write_packer;
  import ddr_fb_pkg::*;

  localparam int unsigned TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         pixel_valid;
  logic         pixel_ready;
  logic [29:0]  pixel_addr;
  logic [15:0]  pixel_data;
  logic         flush;
  logic         flush_done;
  logic         dvalid;
  logic         dready;
  logic [143:0] wdata;
  logic         wlast;
  logic         avalid;
  logic         aready;
  logic [26:0]  waddr;
  logic [31:0]  words;

  always #5 clk = ~clk;

  ddr_write_packer #(.TIMEOUT(TMO), .PIX_ADDR_W(30)) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .pixel_valid_in      (pixel_valid),
    .pixel_ready_out     (pixel_ready),
    .pixel_addr_in       (pixel_addr),
    .pixel_data_in       (pixel_data),
    .flush_in            (flush),
    .flush_done_out      (flush_done),
    .data_fifo_valid_out (dvalid),
    .data_fifo_ready_in  (dready),
    .write_data_out      (wdata),
    .last_write_out      (wlast),
    .addr_fifo_valid_out (avalid),
    .addr_fifo_ready_in  (aready),
    .write_addr_out      (waddr),
    .words_emitted_out   (words)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model: an accumulator of up to eight lanes plus one
  // outgoing word that each FIFO side takes independently.
  bit          m_run;
  bit          m_acc_v;
  logic [26:0] m_acc_addr;
  logic [15:0] m_lane [8];
  bit          m_lw   [8];
  int          m_idle;
  bit          m_fp;
  bit          m_pend, m_dd, m_ad;
  logic [127:0] m_odata;
  logic [15:0]  m_ostrb;
  logic [26:0]  m_oaddr;
  bit           m_olast;
  logic [31:0]  m_words;

  // Captured DUT handshakes for directed literal checks.
  logic [144:0] cap_d [$];
  logic [26:0]  cap_a [$];
  int fd_cyc = -1;
  int dv_rise_cyc = -1;
  bit prev_dv = 1'b0;
  int ready_highs = 0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_acc_v = 0; m_acc_addr = '0; m_idle = 0; m_fp = 0;
    m_pend = 0; m_dd = 0; m_ad = 0; m_odata = '0; m_ostrb = '0;
    m_oaddr = '0; m_olast = 0; m_words = '0;
    for (int i = 0; i < 8; i++) begin m_lane[i] = '0; m_lw[i] = 0; end
  endtask

  task automatic check_zero_outputs();
    chk("rst_ready", 144'(pixel_ready), 144'(0));
    chk("rst_dvalid", 144'(dvalid), 144'(0));
    chk("rst_avalid", 144'(avalid), 144'(0));
    chk("rst_fdone", 144'(flush_done), 144'(0));
    chk("rst_wdata", wdata, 144'(0));
    chk("rst_waddr", 144'(waddr), 144'(0));
    chk("rst_last", 144'(wlast), 144'(0));
    chk("rst_words", 144'(words), 144'(0));
  endtask

  task automatic do_reset(input bit rdy);
    @(negedge clk);
    rst = 1; pixel_valid = 0; pixel_addr = '0; pixel_data = '0; flush = 0;
    dready = rdy; aready = rdy;
    #1;
    check_zero_outputs();
    model_reset();
    prev_dv = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    m_run = 1;
  endtask

  task automatic cycle(input bit pv, input logic [29:0] pa, input logic [15:0] pd,
                       input bit fl, input bit dr, input bit ar);
    bit e_ready, e_dv, e_av, d_hs, a_hs, e_ret, e_fd, acc, miss, flush_mv, tmo_mv;
    logic [26:0] w;
    int ln;
    logic [127:0] ad;
    logic [15:0]  as;
    @(negedge clk);
    pixel_valid = pv; pixel_addr = pa; pixel_data = pd; flush = fl;
    dready = dr; aready = ar;
    #1;
    e_ready = m_run && !m_pend && !m_fp;
    e_dv    = m_pend && !m_dd;
    e_av    = m_pend && !m_ad;
    d_hs    = e_dv && dr;
    a_hs    = e_av && ar;
    e_ret   = m_pend && (m_dd || d_hs) && (m_ad || a_hs);
    e_fd    = (m_fp && !m_pend && !m_acc_v) || (e_ret && m_olast);
    chk("ready", 144'(pixel_ready), 144'(e_ready));
    chk("dvalid", 144'(dvalid), 144'(e_dv));
    chk("avalid", 144'(avalid), 144'(e_av));
    chk("flush_done", 144'(flush_done), 144'(e_fd));
    chk("words", 144'(words), 144'(m_words));
    if (m_pend) begin
      chk("wdata", wdata, {m_odata, m_ostrb});
      chk("waddr", 144'(waddr), 144'(m_oaddr));
      chk("last", 144'(wlast), 144'(m_olast));
    end
    if (dvalid && dr) cap_d.push_back({wlast, wdata});
    if (avalid && ar) cap_a.push_back(waddr);
    if (flush_done) fd_cyc = cyc;
    if (dvalid && !prev_dv) dv_rise_cyc = cyc;
    prev_dv = dvalid;
    if (pixel_ready) ready_highs++;

    acc      = pv && e_ready;
    w        = pa[29:3];
    ln       = int'(pa[2:0]);
    flush_mv = m_fp && !m_pend && m_acc_v;
    tmo_mv   = m_acc_v && (m_idle >= int'(TMO) - 1) && !m_pend && !m_fp && !acc;
    miss     = acc && m_acc_v && (w != m_acc_addr);

    @(posedge clk);
    if (e_ret) begin
      m_pend = 0; m_dd = 0; m_ad = 0; m_words = m_words + 1;
    end else begin
      if (d_hs) m_dd = 1;
      if (a_hs) m_ad = 1;
    end
    if (flush_mv || tmo_mv || miss) begin
      ad = '0; as = '0;
      for (int i = 0; i < 8; i++)
        if (m_lw[i]) begin ad[16*i +: 16] = m_lane[i]; as[2*i +: 2] = 2'b11; end
      m_odata = ad; m_ostrb = as; m_oaddr = m_acc_addr; m_olast = flush_mv;
      m_pend = 1; m_dd = 0; m_ad = 0;
    end
    if (acc) begin
      m_idle = 0;
      if (!m_acc_v || miss)
        for (int i = 0; i < 8; i++) m_lw[i] = 0;
      m_lane[ln] = pd; m_lw[ln] = 1;
      m_acc_v = 1; m_acc_addr = w;
    end else begin
      if (m_acc_v) m_idle++; else m_idle = 0;
      if (flush_mv || tmo_mv) m_acc_v = 0;
    end
    if (e_fd) m_fp = 0;
    else if (fl) m_fp = 1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, 1, 1);
  endtask

  task automatic drain();
    cycle(0, '0, '0, 1, 1, 1);
    idle(6);
  endtask

  initial begin
    int s, f, a;
    logic [31:0] wbefore;
    logic [127:0] exp_d;
    rst = 1; pixel_valid = 0; pixel_addr = '0; pixel_data = '0; flush = 0;
    dready = 0; aready = 0;
    do_reset(1);

    // Full word of eight pixels, then flush.
    s = cap_d.size();
    for (int i = 0; i < 8; i++) cycle(1, 30'(i), 16'(16'h1000 + i), 0, 1, 1);
    f = cyc;
    cycle(0, '0, '0, 1, 1, 1);
    idle(4);
    exp_d = 128'h1007_1006_1005_1004_1003_1002_1001_1000;
    chk("t1_word", cap_d[s][143:0], {exp_d, 16'hFFFF});
    chk("t1_last", 144'(cap_d[s][144]), 144'(1));
    chk("t1_addr", 144'(cap_a[s]), 144'(0));
    chk("t1_done_lat", 144'(fd_cyc - f), 144'(2));
    chk("t1_count", 144'(words), 144'(1));

    // Misses: 9, 17, 9.
    s = cap_d.size();
    cycle(1, 30'd9, 16'h0009, 0, 1, 1);
    cycle(1, 30'd17, 16'h0011, 0, 1, 1);
    idle(1);
    cycle(1, 30'd9, 16'h0099, 0, 1, 1);
    idle(1);
    drain();
    exp_d = 128'h0009 << 16;
    chk("t2_a0", 144'(cap_a[s]), 144'(1));
    chk("t2_s0", 144'(cap_d[s][15:0]), 144'(16'h000C));
    chk("t2_d0", 144'(cap_d[s][143:16]), 144'(exp_d));
    chk("t2_a1", 144'(cap_a[s+1]), 144'(2));
    chk("t2_s1", 144'(cap_d[s+1][15:0]), 144'(16'h000C));

    // Same lane written twice: last write wins.
    s = cap_d.size();
    cycle(1, 30'd3, 16'hAAAA, 0, 1, 1);
    cycle(1, 30'd3, 16'h5555, 0, 1, 1);
    drain();
    chk("t3_lane3", 144'(cap_d[s][79:64]), 144'(16'h5555));
    chk("t3_strb", 144'(cap_d[s][15:0]), 144'(16'h00C0));
    chk("t3_last", 144'(cap_d[s][144]), 144'(1));

    // Address FIFO stalled for 5 cycles.
    cycle(1, 30'd100, 16'h1234, 0, 1, 1);
    wbefore = words;
    cycle(1, 30'd200, 16'h4321, 0, 1, 0);
    s = cap_d.size();
    ready_highs = 0;
    for (int i = 0; i < 5; i++) cycle(1, 30'd300, 16'h0, 0, 1, 0);
    chk("t4_data_hs", 144'(cap_d.size() - s), 144'(1));
    chk("t4_ready_low", 144'(ready_highs), 144'(0));
    cycle(0, '0, '0, 0, 1, 1);
    cycle(0, '0, '0, 0, 0, 0);
    chk("t4_retire_once", 144'(words - wbefore), 144'(1));
    drain();

    // Timeout of a lone pixel.
    s = cap_d.size();
    a = cyc;
    cycle(1, 30'd40, 16'hBEEF, 0, 1, 1);
    idle(TMO + 4);
    chk("t5_latency", 144'(dv_rise_cyc - a), 144'(TMO + 1));
    chk("t5_addr", 144'(cap_a[s]), 144'(5));
    chk("t5_last", 144'(cap_d[s][144]), 144'(0));
    drain();

    // Randomised traffic.
    for (int p = 0; p < 15; p++) begin
      int dens;
      dens = $urandom_range(5, 95);
      for (int i = 0; i < 200; i++) begin
        logic [29:0] pa;
        if ($urandom_range(0, 9) == 0) pa = 30'($urandom());
        else pa = 30'($urandom_range(0, 47));
        cycle($urandom_range(0, 99) < dens, pa, 16'($urandom()),
              $urandom_range(0, 49) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end
    end
    drain();

    // Reset while a word is pending with the address side already done.
    cycle(1, 30'd0, 16'h1111, 0, 1, 1);
    cycle(1, 30'd8, 16'h2222, 0, 0, 1);
    cycle(0, '0, '0, 0, 0, 1);
    s = cap_d.size();
    do_reset(1);
    idle(20);
    chk("t6_no_replay", 144'(cap_d.size() - s), 144'(0));
    chk("t6_count", 144'(words), 144'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
